xadc_channel_sequencer: RTL and testbench

XADC_CHANNEL_SEQUENCER -- requirements
Module: xadc_channel_sequencer

---
 rtl/xadc_pkg.sv | 42 ++++
 rtl/xadc_rr_next.sv | 28 ++
 rtl/xadc_channel_sequencer.sv | 145 ++++++++++++++
 tb/tb_xadc_channel_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC auxiliary-channel sequencer: state encoding,
// per-channel DRP addresses and small channel-selection helpers.
package xadc_pkg;

  localparam int CH_W = 2;
  localparam int N_CH = 4;

  localparam logic [6:0] ADDR_VAUX2  = 7'h12;
  localparam logic [6:0] ADDR_VAUX3  = 7'h13;
  localparam logic [6:0] ADDR_VAUX10 = 7'h1A;
  localparam logic [6:0] ADDR_VAUX11 = 7'h1B;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EOC,
    ISSUE,
    WAIT_DRDY,
    DELIVER
  } state_t;

  function automatic logic [6:0] ch_addr(input logic [CH_W-1:0] ch);
    logic [6:0] addr;
    case (ch)
      2'd0:    addr = ADDR_VAUX2;
      2'd1:    addr = ADDR_VAUX3;
      2'd2:    addr = ADDR_VAUX10;
      default: addr = ADDR_VAUX11;
    endcase
    return addr;
  endfunction

  // Lowest enabled channel; 0 when nothing is enabled.
  function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] mask);
    logic [CH_W-1:0] ch;
    ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) ch = CH_W'(i);
    end
    return ch;
  endfunction

endpackage

// File: rtl/xadc_rr_next.sv
// Round-robin pick of the next enabled channel strictly above the current one,
// wrapping 3 -> 0; falls back to the current channel when no other bit is set.
module xadc_rr_next
  import xadc_pkg::*;
(
  input  logic [CH_W-1:0] current,
  input  logic [N_CH-1:0] mask,
  output logic [CH_W-1:0] next_ch
);

  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    next_ch = current;
    idx     = '0;
    found   = 1'b0;
    // Offset N_CH wraps back onto the current channel itself.
    for (int k = 1; k <= N_CH; k++) begin
      idx = current + CH_W'(k);
      if (!found && mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_channel_sequencer.sv
// Round-robin XADC auxiliary-channel sequencer: waits for EOC, issues a DRP
// read per enabled channel, delivers the 12-bit code. Define
// XADC_SEQ_AVERAGE_EN to average four consecutive reads per channel.
module xadc_channel_sequencer
  import xadc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SAMPLE_MSB     = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  channel_mask,
  input  logic        eoc_in,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        sample_valid,
  output logic [1:0]  sample_channel,
  output logic [11:0] sample_data,
  output logic        timeout_err,
  output logic        busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  state_t          state_nxt;
  logic [CH_W-1:0] ch_ptr;
  logic [CH_W-1:0] ch_next;
  logic [TO_W-1:0] to_cnt;
  logic [11:0]     code;
  logic [11:0]     result;
  logic [11:0]     sample_data_q;
  logic [1:0]      sample_channel_q;
  logic            drdy_hit;
  logic            to_hit;
  logic            last_read;
  logic            unused_do;

  assign code      = do_in[SAMPLE_MSB -: 12];
  assign unused_do = ^do_in;
  assign drdy_hit  = (state == WAIT_DRDY) && drdy_in;
  // drdy_in beats a timeout landing on the same cycle.
  assign to_hit    = (state == WAIT_DRDY) && !drdy_in &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  xadc_rr_next u_rr_next (
    .current (ch_ptr),
    .mask    (channel_mask),
    .next_ch (ch_next)
  );

`ifdef XADC_SEQ_AVERAGE_EN
  logic [13:0] acc_q;
  logic [1:0]  rd_cnt_q;
  logic [13:0] acc_sum;

  assign acc_sum   = acc_q + 14'(code);
  assign last_read = (rd_cnt_q == 2'd3);
  assign result    = acc_sum[13:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      rd_cnt_q <= '0;
    end else if (state == IDLE || to_hit || (drdy_hit && last_read)) begin
      acc_q    <= '0;
      rd_cnt_q <= '0;
    end else if (drdy_hit) begin
      acc_q    <= acc_sum;
      rd_cnt_q <= rd_cnt_q + 2'd1;
    end
  end
`else
  assign last_read = 1'b1;
  assign result    = code;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable && (channel_mask != 4'd0)) state_nxt = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (!enable || (channel_mask == 4'd0)) state_nxt = IDLE;
        else if (eoc_in)                       state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT_DRDY;
      WAIT_DRDY: begin
        if (drdy_in) begin
          if (last_read)   state_nxt = DELIVER;
          else if (enable) state_nxt = WAIT_EOC;
          else             state_nxt = IDLE;
        end else if (to_hit) begin
          state_nxt = enable ? WAIT_EOC : IDLE;
        end
      end
      DELIVER: state_nxt = enable ? WAIT_EOC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    den_out        = (state == ISSUE);
    busy           = (state == ISSUE) || (state == WAIT_DRDY);
    sample_valid   = (state == DELIVER);
    timeout_err    = to_hit;
    daddr_out      = ch_addr(ch_ptr);
    sample_data    = sample_data_q;
    sample_channel = sample_channel_q;
  end

  // The pointer only moves on leaving IDLE, on delivery and on timeout, so
  // daddr_out stays put for the whole read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_ptr           <= '0;
      to_cnt           <= '0;
      sample_data_q    <= '0;
      sample_channel_q <= '0;
    end else begin
      if (state == IDLE && state_nxt == WAIT_EOC && !channel_mask[ch_ptr])
        ch_ptr <= lowest_ch(channel_mask);
      else if (state == DELIVER || to_hit)
        ch_ptr <= ch_next;

      if (state == ISSUE)          to_cnt <= '0;
      else if (state == WAIT_DRDY) to_cnt <= to_cnt + TO_W'(1);

      if (drdy_hit && last_read) begin
        sample_channel_q <= ch_ptr;
        sample_data_q    <= result;
      end
    end
  end

endmodule

// File: tb/tb_xadc_channel_sequencer.sv
// Directed-plus-random bench for xadc_channel_sequencer against a
// transaction-level model of channel order, sample values and timeouts.
module tb_xadc_channel_sequencer;

`ifdef XADC_SEQ_AVERAGE_EN
  localparam int AVG_N = 4;
`else
  localparam int AVG_N = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  channel_mask;
  logic        eoc_in;
  logic [6:0]  daddr_out;
  logic        den_out;
  logic        drdy_in;
  logic [15:0] do_in;
  logic        sample_valid;
  logic [1:0]  sample_channel;
  logic [11:0] sample_data;
  logic        timeout_err;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  bit          m_idle;
  int          m_cnt;
  int          m_acc;
  logic [11:0] m_data;
  logic [1:0]  m_ch;
  logic [11:0] exp_q[$];
  logic [6:0]  addr_tab [0:3] = '{7'h12, 7'h13, 7'h1A, 7'h1B};

  xadc_channel_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .channel_mask   (channel_mask),
    .eoc_in         (eoc_in),
    .daddr_out      (daddr_out),
    .den_out        (den_out),
    .drdy_in        (drdy_in),
    .do_in          (do_in),
    .sample_valid   (sample_valid),
    .sample_channel (sample_channel),
    .sample_data    (sample_data),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_ch(input int cur, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  function automatic int low_ch(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_idle = 1;
    m_cnt  = 0;
    m_acc  = 0;
    m_data = '0;
    m_ch   = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_daddr"}, daddr_out, 7'h12);
    check({tag, "_den"}, den_out, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_chan"}, sample_channel, 0);
    check({tag, "_data"}, sample_data, 0);
    check({tag, "_tmo"}, timeout_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One eoc -> read exchange. dly = clocks from den to drdy (0 = never).
  // mask_rd is applied and enable optionally dropped while the read is open.
  task automatic read_txn(input int gap, input int dly, input logic [15:0] dval,
                          input bit drop_en, input logic [3:0] mask_rd);
    int  issue_ptr;
    bit  got;
    logic [11:0] exp_d;
    got = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clock);
      if (g == 0) begin
        enable = 1'b1;
        if (m_idle) begin
          if (!channel_mask[m_ptr]) m_ptr = low_ch(channel_mask);
          m_idle = 0;
        end
      end
      eoc_in  = 1'b0;
      drdy_in = 1'($urandom_range(0, 1));
      do_in   = 16'($urandom);
      #1;
      check("gap_den", den_out, 0);
      check("gap_valid", sample_valid, 0);
      if (g == gap - 1) begin
        check("hold_data", sample_data, m_data);
        check("hold_chan", sample_channel, m_ch);
      end
    end
    @(negedge clock);
    eoc_in  = 1'b1;
    drdy_in = 1'b0;
    #1;
    check("eoc_den", den_out, 0);
    @(negedge clock);
    eoc_in       = 1'b0;
    channel_mask = mask_rd;
    if (drop_en) enable = 1'b0;
    #1;
    check("issue_den", den_out, 1);
    check("issue_busy", busy, 1);
    check("issue_daddr", daddr_out, addr_tab[m_ptr]);
    issue_ptr = m_ptr;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clock);
      drdy_in = (j == dly);
      do_in   = (j == dly) ? dval : 16'($urandom);
      eoc_in  = ($urandom_range(0, 3) == 0);
      #1;
      check("wait_den", den_out, 0);
      check("wait_busy", busy, 1);
      check("wait_daddr", daddr_out, addr_tab[issue_ptr]);
      check("wait_valid", sample_valid, 0);
      check("wait_tmo", timeout_err, (j == 64) && (dly != j));
      if (j == dly) begin
        got = 1;
        break;
      end
    end
    @(negedge clock);
    eoc_in  = 1'b0;
    drdy_in = 1'b0;
    #1;
    check("post_tmo", timeout_err, 0);
    if (got) begin
      m_acc += int'(dval[15:4]);
      m_cnt++;
      if (m_cnt == AVG_N) begin
        exp_q.push_back(12'(m_acc / AVG_N));
        m_acc = 0;
        m_cnt = 0;
        check("deliver_valid", sample_valid, 1);
        exp_d = exp_q.pop_front();
        check("deliver_data", sample_data, exp_d);
        check("deliver_chan", sample_channel, issue_ptr);
        m_data = exp_d;
        m_ch   = 2'(issue_ptr);
        m_ptr  = next_ch(m_ptr, channel_mask);
      end else begin
        check("partial_valid", sample_valid, 0);
      end
    end else begin
      check("tmo_valid", sample_valid, 0);
      m_acc = 0;
      m_cnt = 0;
      m_ptr = next_ch(m_ptr, channel_mask);
    end
    if (!enable) begin
      m_idle = 1;
      m_acc  = 0;
      m_cnt  = 0;
    end
  endtask

  // Reset landing while a read is outstanding, with a stray drdy afterwards.
  task automatic reset_mid_read();
    read_prefix();
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check_reset_outs("rst_assert");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      drdy_in = (c == 2);
      do_in   = 16'($urandom);
      #1;
      check_reset_outs("rst_after");
    end
    drdy_in = 1'b0;
  endtask

  task automatic read_prefix();
    for (int g = 0; g < 3; g++) begin
      @(negedge clock);
      enable  = 1'b1;
      eoc_in  = 1'b0;
      drdy_in = 1'b0;
    end
    @(negedge clock);
    eoc_in = 1'b1;
    @(negedge clock);
    eoc_in = 1'b0;
    #1;
    check("rst_issue_den", den_out, 1);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_wait_busy", busy, 1);
  endtask

  initial begin
    int dens;
    int dly;
    logic [3:0] mk;

    reset        = 1'b1;
    enable       = 1'b0;
    channel_mask = 4'h0;
    eoc_in       = 1'b0;
    drdy_in      = 1'b0;
    do_in        = 16'h0;
    model_reset();
    @(negedge clock);
    #1;
    check_reset_outs("por");
    @(negedge clock);
    reset = 1'b0;

    // Full mask, eoc roughly every 100 clocks, drdy 3 clocks after den
    channel_mask = 4'hF;
    for (int i = 0; i < 5; i++) read_txn(95, 3, 16'($urandom), 0, 4'hF);

    // Data extraction with drdy one clock after den
    read_txn(4, 1, 16'hABC0, 0, 4'hF);

    // Reset during WAIT_DRDY, then sparse mask starting from pointer 0
    reset_mid_read();
    channel_mask = 4'b1010;
    for (int i = 0; i < 4 * AVG_N; i++) read_txn(3, 2, 16'($urandom), 0, 4'b1010);

    // Empty mask: nothing issued even with eoc pulses
    @(negedge clock);
    channel_mask = 4'h0;
    dens = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      eoc_in  = ((c % 10) == 0);
      drdy_in = 1'($urandom_range(0, 1));
      #1;
      if (den_out) dens++;
    end
    eoc_in  = 1'b0;
    drdy_in = 1'b0;
    check("mask0_den_count", dens, 0);
    check("mask0_busy", busy, 0);
    m_idle = 1;
    channel_mask = 4'hF;

    // Timeout, drdy/timeout tie, and the read after a timeout
    read_txn(3, 0, 16'h0, 0, 4'hF);
    read_txn(3, 0, 16'h0, 0, 4'hF);
    read_txn(3, 64, 16'h5A50, 0, 4'hF);
    read_txn(3, 2, 16'($urandom), 0, 4'hF);

    // Enable dropped mid-read: read completes, then the block stays idle
    read_txn(3, 5, 16'($urandom), 1, 4'hF);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      eoc_in = ((c % 4) == 0);
      #1;
      check("disabled_den", den_out, 0);
    end
    eoc_in = 1'b0;

    // Averaging run: codes 0x100..0x103 on one channel
    reset_mid_read();
    channel_mask = 4'hF;
    for (int i = 0; i < 4; i++) read_txn(3, 2, 16'(((256 + i) << 4) | 5), 0, 4'hF);

    // Mask narrowed during a read does not abort it
    read_txn(3, 4, 16'($urandom), 0, 4'b0100);
    read_txn(3, 4, 16'($urandom), 0, 4'b0100);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      mk  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : channel_mask;
      read_txn($urandom_range(2, 8), dly, 16'($urandom), ($urandom_range(0, 7) == 0), mk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
